seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a multi-digit hex 7-segment display: one shared segment bus, one anode enable per digit.
Holds a DIGITS-wide nibble frame in a display register.
New frames are loaded through a shadow register and committed only at frame boundaries, so the display never tears.
Sits between CPU/MMIO or debug logic and board display pins; replaces per-digit combinational decoders.

---
 rtl/seg7_scan_driver.sv | 134 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment scan driver with shadowed, tear-free frame commits.
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame_done,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(SCAN_DIV - 1);
  localparam bit SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam bit AN_LOW  = (AN_ACTIVE_LOW != 0);

  logic [DW-1:0]         div;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   disp;
  logic [DIGITS-1:0]     disp_dp;
  logic [4*DIGITS-1:0]   shadow;
  logic [DIGITS-1:0]     shadow_dp;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            cur_nib;
  logic                  cur_en;
  logic                  blank;
  logic [6:0]            seg_low;
  logic                  dp_lit;
  logic [DIGITS-1:0]     an_onehot;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [DIGITS-1:0]     an_next;

  // Active-low {g,f,e,d,c,b,a} patterns.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  assign tick     = (div == DIV_MAX);
  assign boundary = tick && (idx == LAST_IDX);
  assign cur_nib  = disp[{idx, 2'b00} +: 4];
  assign cur_en   = digit_en[idx];

`ifdef SEG7_LZ_BLANK_EN
  // Highest nonzero digit of the committed frame; digit 0 is never blanked.
  logic [IW-1:0] lz_top;
  always_comb begin
    lz_top = '0;
    for (int i = 0; i < DIGITS; i++)
      if (disp[4*i +: 4] != 4'h0) lz_top = IW'(i);
  end
  assign blank = (idx > lz_top);
`else
  assign blank = 1'b0;
`endif

  assign seg_low   = (cur_en && !blank) ? hex_decode(cur_nib) : 7'h7F;
  assign dp_lit    = cur_en && !blank && disp_dp[idx];
  assign an_onehot = cur_en ? (DIGITS'(1) << idx) : '0;
  assign seg_next  = SEG_LOW ? seg_low : ~seg_low;
  assign dp_next   = SEG_LOW ? ~dp_lit : dp_lit;
  assign an_next   = AN_LOW ? ~an_onehot : an_onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div        <= '0;
      idx        <= '0;
      disp       <= '0;
      disp_dp    <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      seg_out    <= SEG_LOW ? 7'h7F : 7'h00;
      dp_out     <= SEG_LOW;
      an_out     <= AN_LOW ? '1 : '0;
    end else begin
      frame_done <= 1'b0;
      seg_out    <= seg_next;
      dp_out     <= dp_next;
      an_out     <= an_next;
      if (tick) begin
        div <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
      if (boundary && pending) begin
        disp       <= shadow;
        disp_dp    <= shadow_dp;
        pending    <= 1'b0;
        frame_done <= 1'b1;
      end
      // A load in the commit cycle refills the shadow and keeps pending set.
      if (load) begin
        shadow    <= value_in;
        shadow_dp <= dp_in;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGITS=4, SCAN_DIV=4, active-low segments and anodes.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic        pending;
  logic        frame_done;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg7_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in),
    .digit_en(digit_en), .load(load), .pending(pending),
    .frame_done(frame_done), .seg_out(seg_out), .dp_out(dp_out),
    .an_out(an_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
  endtask

  // Advance to 1ns after posedge number n since reset release.
  task automatic adv_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk_digit(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    chk({tag, "_an"}, 16'(an_out), 16'(an));
    chk({tag, "_seg"}, 16'(seg_out), 16'(seg));
    chk({tag, "_dp"}, 16'(dp_out), 16'(dp));
  endtask

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  initial begin
    rst = 1'b1; value_in = '0; dp_in = '0; digit_en = 4'hF; load = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_an", 16'(an_out), 16'hF);
    chk("rst_seg", 16'(seg_out), 16'h7F);
    chk("rst_dp", 16'(dp_out), 16'h1);
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_fd", 16'(frame_done), 16'h0);
    rst = 1'b0;
    cyc = 0;

    // 1: anode walk over an all-zero frame
    adv_to(1);  chk_digit("walk0", 4'hE, 7'h40, 1'b1);
    adv_to(4);  chk_digit("walk0_hold", 4'hE, 7'h40, 1'b1);
    adv_to(5);  chk_digit("walk1", 4'hD, 7'h40, 1'b1);
    adv_to(9);  chk_digit("walk2", 4'hB, 7'h40, 1'b1);
    adv_to(13); chk_digit("walk3", 4'h7, 7'h40, 1'b1);
    chk("walk_pending", 16'(pending), 16'h0);

    // 2: mid-frame load commits at boundary (posedge 16)
    value_in = 16'h12AF; dp_in = 4'b0001; load = 1'b1;
    adv_to(14); load = 1'b0;
    chk("ld_pending", 16'(pending), 16'h1);
    chk("ld_fd_early", 16'(frame_done), 16'h0);
    adv_to(15); chk("ld_pending2", 16'(pending), 16'h1);
    chk_digit("ld_old_frame", 4'h7, 7'h40, 1'b1);
    adv_to(16);
    chk("commit_fd", 16'(frame_done), 16'h1);
    chk("commit_pending", 16'(pending), 16'h0);
    adv_to(17);
    chk("commit_fd_end", 16'(frame_done), 16'h0);
    chk_digit("f1_d0", 4'hE, 7'h0E, 1'b0);
    adv_to(21); chk_digit("f1_d1", 4'hD, 7'h08, 1'b1);
    adv_to(25); chk_digit("f1_d2", 4'hB, 7'h24, 1'b1);
    adv_to(29); chk_digit("f1_d3", 4'h7, 7'h79, 1'b1);

    // 3: two loads before boundary 32, last one wins
    value_in = 16'h1111; dp_in = 4'b0000; load = 1'b1;
    adv_to(30); value_in = 16'h2222;
    adv_to(31); load = 1'b0;
    chk("dbl_pending", 16'(pending), 16'h1);
    chk("dbl_fd_pre", 16'(frame_done), 16'h0);
    adv_to(32); chk("dbl_fd", 16'(frame_done), 16'h1);
    adv_to(33); chk("dbl_fd_end", 16'(frame_done), 16'h0);
    chk_digit("f2_d0", 4'hE, 7'h24, 1'b1);
    adv_to(37); chk_digit("f2_d1", 4'hD, 7'h24, 1'b1);

    // 4: load coincident with boundary 48 while pending
    adv_to(39); value_in = 16'h3333; load = 1'b1;
    adv_to(40); load = 1'b0;
    adv_to(47); value_in = 16'h4444; load = 1'b1;
    adv_to(48); load = 1'b0;
    chk("coin_fd", 16'(frame_done), 16'h1);
    chk("coin_pending", 16'(pending), 16'h1);
    adv_to(49); chk_digit("f3_d0", 4'hE, 7'h30, 1'b1);
    chk("coin_pending2", 16'(pending), 16'h1);
    adv_to(64);
    chk("coin2_fd", 16'(frame_done), 16'h1);
    chk("coin2_pending", 16'(pending), 16'h0);
    adv_to(65); chk_digit("f4_d0", 4'hE, 7'h19, 1'b1);

    // 5: digit_en masking
    adv_to(66); digit_en = 4'b0101;
    adv_to(69); chk_digit("en_d1", 4'hF, 7'h7F, 1'b1);
    adv_to(73); chk_digit("en_d2", 4'hB, 7'h19, 1'b1);
    adv_to(77); chk_digit("en_d3", 4'hF, 7'h7F, 1'b1);
    adv_to(81); chk_digit("en_d0", 4'hE, 7'h19, 1'b1);

    // 6: leading-zero frame, committed at boundary 96
    value_in = 16'h0030; load = 1'b1;
    adv_to(82); load = 1'b0; digit_en = 4'hF;
    adv_to(97);  chk_digit("lz_d0", 4'hE, 7'h40, 1'b1);
    adv_to(101); chk_digit("lz_d1", 4'hD, 7'h30, 1'b1);
    adv_to(105); chk_digit("lz_d2", 4'hB, LZ_SEG, 1'b1);
    adv_to(109); chk_digit("lz_d3", 4'h7, LZ_SEG, 1'b1);

    // Reset mid-scan with a pending frame
    adv_to(110); value_in = 16'h5555; load = 1'b1;
    adv_to(111); load = 1'b0;
    chk("pre_rst_pending", 16'(pending), 16'h1);
    rst = 1'b1;
    #1;
    chk("arst_an", 16'(an_out), 16'hF);
    chk("arst_seg", 16'(seg_out), 16'h7F);
    chk("arst_dp", 16'(dp_out), 16'h1);
    chk("arst_pending", 16'(pending), 16'h0);
    #1;
    rst = 1'b0;
    cyc = 0;
    adv_to(1);  chk_digit("rs_d0", 4'hE, 7'h40, 1'b1);
    chk("rs_pending", 16'(pending), 16'h0);
    adv_to(16); chk("rs_no_commit", 16'(frame_done), 16'h0);
    adv_to(17); chk_digit("rs_f_d0", 4'hE, 7'h40, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
